// File: rtl/frame_pkg.sv
// Shared framing constants for the PAM transmit framer and receive-side frame stripper.
// Sync pattern goes out MSB first; the receiver's shift register holds the newest symbol at bit 0.
package frame_pkg;

   localparam int              SYNC_LEN = 60;
   localparam logic [SYNC_LEN-1:0] SYNC_PAT = {15'b000_0101_0011_0111, 45'b0};
   localparam logic [11:0]     IDLE_LVL = 12'h080;

   typedef enum logic [1:0] {
      ST_HUNT  = 2'd0,
      ST_PILOT = 2'd1,
      ST_DATA  = 2'd2
   } frame_state_e;

endpackage

// File: rtl/strip_head_frame_if.sv
// Payload word stream toward the PAM demapper: valid/ready, one 2-sample word per transfer.
// Word layout is {earlier sample, later sample}.
interface strip_head_frame_if #(
   parameter int W = 24
);
   logic [W-1:0] pam_data;
   logic         valid;
   logic         ready;

   modport master (output pam_data, output valid, input ready);
   modport slave  (input pam_data, input valid, output ready);
endinterface

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO, 2^AW entries; a write into a full FIFO is accepted only with a same-cycle read.
// Read data is valid combinationally whenever empty is low.
module sync_fifo #(
   parameter int WIDTH = 24,
   parameter int AW    = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_dat,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_dat,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      count
);
   localparam int DEPTH = 1 << AW;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             wr_ok, rd_ok;

   assign full   = (count_q == (AW+1)'(DEPTH));
   assign empty  = (count_q == '0);
   assign count  = count_q;
   assign rd_dat = mem_q[rd_ptr_q];

   always_comb begin
      wr_ok    = wr_en && (!full || rd_en);
      rd_ok    = rd_en && !empty;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_ok) rd_ptr_d = rd_ptr_q + AW'(1);
      if (wr_ok && !rd_ok)      count_d = count_q + (AW+1)'(1);
      else if (!wr_ok && rd_ok) count_d = count_q - (AW+1)'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset; only occupancy tracking has to be cleared.
   always_ff @(posedge clk) begin
      if (wr_ok) mem_q[wr_ptr_q] <= wr_dat;
   end
endmodule

// File: rtl/strip_head_frame.sv
// Hunts the sync header in the ADC stream, captures pilots, packs payload pairs into a FWFT output FIFO.
// Word visible one cycle after its second sample; ADC side never stalls, so a full FIFO drops words and sets overflow.
module strip_head_frame
   import frame_pkg::*;
#(
   parameter int AD_CVER_WIDTH  = 12,
   parameter int ADDR_MEM_WIDTH = 10,
   parameter int PAM_ORDER      = 4,
   parameter int SYNC_MAX_ERR   = 3,
   parameter int SYNC_THR       = 1024,
   parameter int FIFO_AW        = 4
) (
   input  logic                                      clk,
   input  logic                                      rst_n,
   input  logic [AD_CVER_WIDTH-1:0]                  adc_data,
   strip_head_frame_if.master                        M_out,
   output logic [(1<<PAM_ORDER)*AD_CVER_WIDTH-1:0]   pilot_levels,
   output logic                                      pilot_valid,
   output logic                                      frame_sync,
   output logic [15:0]                               frame_cnt,
   output logic                                      overflow,
   input  logic                                      stat_clr
);
   localparam int                        W         = AD_CVER_WIDTH;
   localparam int                        NP        = 1 << PAM_ORDER;
   localparam logic signed [W-1:0]       SLICE_THR = W'(SYNC_THR);
   localparam logic [PAM_ORDER-1:0]      PIL_LAST  = '1;
   localparam logic [ADDR_MEM_WIDTH-1:0] DAT_LAST  = '1;

   function automatic int popcount(input logic [SYNC_LEN-1:0] v);
      int n;
      n = 0;
      for (int i = 0; i < SYNC_LEN; i++) n += int'(v[i]);
      return n;
   endfunction

   frame_state_e                 state_q, state_d;
   logic [SYNC_LEN-1:0]          shreg_q, shreg_d, shifted;
   logic [PAM_ORDER-1:0]         pil_idx_q, pil_idx_d;
   logic [ADDR_MEM_WIDTH-1:0]    dat_idx_q, dat_idx_d;
   logic [W-1:0]                 hold_q, hold_d;
   logic [NP-2:0][W-1:0]         shadow_q, shadow_d;
   logic [NP-1:0][W-1:0]         pilot_levels_q, pilot_levels_d;
   logic                         pilot_valid_q, pilot_valid_d;
   logic                         frame_sync_q, frame_sync_d;
   logic [15:0]                  frame_cnt_q, frame_cnt_d;
   logic                         overflow_q, overflow_d;

   logic                         slice_bit, push, pop, drop;
   logic [2*W-1:0]               push_dat, fifo_rd_dat;
   logic                         fifo_full, fifo_empty;
   logic [FIFO_AW:0]             fifo_cnt;

   assign M_out.valid    = (fifo_cnt != '0);
   assign M_out.pam_data = fifo_empty ? '0 : fifo_rd_dat;
   assign pop            = M_out.valid && M_out.ready;

   assign pilot_levels = pilot_levels_q;
   assign pilot_valid  = pilot_valid_q;
   assign frame_sync   = frame_sync_q;
   assign frame_cnt    = frame_cnt_q;
   assign overflow     = overflow_q;

   always_comb begin
      state_d        = state_q;
      shreg_d        = shreg_q;
      pil_idx_d      = pil_idx_q;
      dat_idx_d      = dat_idx_q;
      hold_d         = hold_q;
      shadow_d       = shadow_q;
      pilot_levels_d = pilot_levels_q;
      pilot_valid_d  = 1'b0;
      frame_sync_d   = 1'b0;
      frame_cnt_d    = frame_cnt_q;
      overflow_d     = overflow_q;
      push           = 1'b0;
      push_dat       = {hold_q, adc_data};

      slice_bit = ($signed(adc_data) > SLICE_THR);
      shifted   = {shreg_q[SYNC_LEN-2:0], slice_bit};

      // Lock decision uses the sample on the wire this cycle, so the very next sample is pilot 0.
      unique case (state_q)
         ST_HUNT: begin
            shreg_d = shifted;
            if (popcount(shifted ^ SYNC_PAT) <= SYNC_MAX_ERR) begin
               state_d      = ST_PILOT;
               shreg_d      = '0;
               pil_idx_d    = '0;
               frame_sync_d = 1'b1;
               frame_cnt_d  = frame_cnt_q + 16'd1;
            end
         end
         ST_PILOT: begin
            pil_idx_d = pil_idx_q + PAM_ORDER'(1);
            if (pil_idx_q == PIL_LAST) begin
               pilot_levels_d = {adc_data, shadow_q};
               pilot_valid_d  = 1'b1;
               dat_idx_d      = '0;
               state_d        = ST_DATA;
            end else begin
               shadow_d[pil_idx_q] = adc_data;
            end
         end
         ST_DATA: begin
            dat_idx_d = dat_idx_q + ADDR_MEM_WIDTH'(1);
            if (!dat_idx_q[0]) hold_d = adc_data;
            else               push   = 1'b1;
            if (dat_idx_q == DAT_LAST) begin
               state_d = ST_HUNT;
               shreg_d = '0;
            end
         end
         default: begin
            state_d = ST_HUNT;
            shreg_d = '0;
         end
      endcase

      drop = push && fifo_full && !pop;
      if (drop) overflow_d = 1'b1;
      if (stat_clr) begin
         frame_cnt_d = '0;
         overflow_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_HUNT;
         shreg_q        <= '0;
         pil_idx_q      <= '0;
         dat_idx_q      <= '0;
         hold_q         <= '0;
         shadow_q       <= '0;
         pilot_levels_q <= '0;
         pilot_valid_q  <= 1'b0;
         frame_sync_q   <= 1'b0;
         frame_cnt_q    <= '0;
         overflow_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         shreg_q        <= shreg_d;
         pil_idx_q      <= pil_idx_d;
         dat_idx_q      <= dat_idx_d;
         hold_q         <= hold_d;
         shadow_q       <= shadow_d;
         pilot_levels_q <= pilot_levels_d;
         pilot_valid_q  <= pilot_valid_d;
         frame_sync_q   <= frame_sync_d;
         frame_cnt_q    <= frame_cnt_d;
         overflow_q     <= overflow_d;
      end
   end

   sync_fifo #(
      .WIDTH (2*W),
      .AW    (FIFO_AW)
   ) u_fifo (
      .clk    (clk),
      .rst_n  (rst_n),
      .wr_en  (push),
      .wr_dat (push_dat),
      .rd_en  (pop),
      .rd_dat (fifo_rd_dat),
      .full   (fifo_full),
      .empty  (fifo_empty),
      .count  (fifo_cnt)
   );
endmodule

// File: tb/tb_strip_head_frame.sv
// Bench for strip_head_frame: randomized sample streams parsed by a stream-level frame model,
// DUT pulses, counters, pilots and popped words compared against it.
module tb_strip_head_frame;
   import frame_pkg::*;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [11:0]  adc_data;
   logic [191:0] pilot_levels;
   logic         pilot_valid, frame_sync, overflow, stat_clr;
   logic [15:0]  frame_cnt;

   strip_head_frame_if #(.W(24)) m_if ();

   strip_head_frame #(
      .AD_CVER_WIDTH (12), .ADDR_MEM_WIDTH (10), .PAM_ORDER (4),
      .SYNC_MAX_ERR (3), .SYNC_THR (1024), .FIFO_AW (4)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .adc_data     (adc_data),
      .M_out        (m_if),
      .pilot_levels (pilot_levels),
      .pilot_valid  (pilot_valid),
      .frame_sync   (frame_sync),
      .frame_cnt    (frame_cnt),
      .overflow     (overflow),
      .stat_clr     (stat_clr)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- stimulus stream ----------------
   logic [11:0] s_dat[$];
   bit          s_rdy[$];
   bit          s_clr[$];
   logic [59:0] pat;

   task automatic new_stream();
      s_dat.delete(); s_rdy.delete(); s_clr.delete();
   endtask

   task automatic put(input logic [11:0] d);
      s_dat.push_back(d); s_rdy.push_back(1'b1); s_clr.push_back(1'b0);
   endtask

   function automatic logic [11:0] lvl(input bit b);
      if (b) return 12'($urandom_range(1025, 2047));
      case ($urandom_range(0, 3))
         0:       return IDLE_LVL;
         1:       return 12'd1024;
         2:       return 12'($urandom_range(0, 1024));
         default: return 12'h800 | 12'($urandom_range(0, 2047));
      endcase
   endfunction

   task automatic add_idle(input int n, input bit fixed);
      for (int k = 0; k < n; k++) put(fixed ? IDLE_LVL : lvl(1'b0));
   endtask

   // pay_kind: 0 counting, 1 random, 2 random with the exact sync pattern embedded
   task automatic add_frame(input logic [59:0] flip, input bit cnt_pil, input int pay_kind);
      for (int b = 59; b >= 0; b--) put(lvl(pat[b] ^ flip[b]));
      for (int k = 0; k < 16; k++) put(cnt_pil ? 12'(32'h800 + k * 32'h111) : 12'($urandom_range(0, 4095)));
      for (int k = 0; k < 1024; k++) begin
         if (pay_kind == 0)                           put(12'(k));
         else if (pay_kind == 2 && k >= 100 && k < 160) put(lvl(pat[59 - (k - 100)]));
         else                                         put(12'($urandom_range(0, 4095)));
      end
   endtask

   // ---------------- reference model ----------------
   logic [23:0]  m_words[$];
   int           m_lock[$];
   logic [191:0] m_pil;
   logic [15:0]  m_cnt;

   function automatic bit slc(input logic [11:0] v);
      return $signed(v) > 1024;
   endfunction

   // Frame found where the last 60 slicer decisions since hunting restarted are within 3 of the pattern.
   task automatic run_model();
      int hs, i, d;
      hs = 0; i = 0;
      m_words.delete(); m_lock.delete(); m_pil = '0; m_cnt = 0;
      while (i < s_dat.size()) begin
         d = 0;
         for (int j = i - 59; j <= i; j++) begin
            bit wb;
            wb = (j >= hs) ? slc(s_dat[j]) : 1'b0;
            if (wb != pat[i - j]) d++;
         end
         if (d <= 3 && i + 16 + 1024 < s_dat.size()) begin
            m_lock.push_back(i);
            m_cnt = m_cnt + 16'd1;
            for (int k = 0; k < 16; k++) m_pil[k*12 +: 12] = s_dat[i + 1 + k];
            for (int k = 0; k < 512; k++) m_words.push_back({s_dat[i + 17 + 2*k], s_dat[i + 18 + 2*k]});
            hs = i + 17 + 1024;
            for (int j = i; j < hs; j++) if (s_clr[j]) m_cnt = 0;
            i = hs;
         end else begin
            if (s_clr[i]) m_cnt = 0;
            i++;
         end
      end
   endtask

   // ---------------- driver / monitor ----------------
   logic [23:0]  got[$];
   int           n_sync, n_pv, sync_iter, pv_iter, fv_iter;
   logic [191:0] seen_pil;

   task automatic observe(input int i);
      if (frame_sync) begin n_sync++; if (sync_iter < 0) sync_iter = i; end
      if (pilot_valid) begin n_pv++; seen_pil = pilot_levels; if (pv_iter < 0) pv_iter = i; end
      if (m_if.valid && fv_iter < 0) fv_iter = i;
      if (m_if.valid && m_if.ready) got.push_back(m_if.pam_data);
   endtask

   task automatic run_stream(input int stop_at);
      got.delete(); n_sync = 0; n_pv = 0; sync_iter = -1; pv_iter = -1; fv_iter = -1; seen_pil = '0;
      for (int i = 0; i < s_dat.size(); i++) begin
         if (stop_at >= 0 && i == stop_at) break;
         @(negedge clk);
         adc_data = s_dat[i]; m_if.ready = s_rdy[i]; stat_clr = s_clr[i];
         #1 observe(i);
      end
      if (stop_at < 0) begin
         for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            adc_data = IDLE_LVL; m_if.ready = 1'b1; stat_clr = 1'b0;
            #1 observe(s_dat.size() + k);
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; adc_data = IDLE_LVL; m_if.ready = 1'b1; stat_clr = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic results(input string nm, input int keep, input logic exp_ovf);
      int exp_n, l;
      exp_n = (keep < 0 || keep > m_words.size()) ? m_words.size() : keep;
      check({nm, ".syncs"}, 192'(n_sync), 192'(m_lock.size()));
      check({nm, ".pilot_pulses"}, 192'(n_pv), 192'(m_lock.size()));
      check({nm, ".frame_cnt"}, 192'(frame_cnt), 192'(m_cnt));
      check({nm, ".pilot_levels"}, pilot_levels, m_pil);
      check({nm, ".overflow"}, 192'(overflow), 192'(exp_ovf));
      check({nm, ".nwords"}, 192'(got.size()), 192'(exp_n));
      for (int k = 0; k < got.size() && k < exp_n; k++)
         check({nm, ".word"}, 192'(got[k]), 192'(m_words[k]));
      if (m_lock.size() > 0) begin
         l = m_lock[0];
         check({nm, ".seen_pilots"}, seen_pil, m_pil);
         check({nm, ".sync_lat"}, 192'((sync_iter - l) inside {[1:2]}), 192'(1));
         check({nm, ".pilot_lat"}, 192'((pv_iter - (l + 16)) inside {[1:2]}), 192'(1));
         check({nm, ".word_lat"}, 192'((fv_iter - (l + 18)) inside {[1:2]}), 192'(1));
      end
   endtask

   task automatic build_clean();
      new_stream();
      add_idle(100, 1'b1);
      add_frame(60'b0, 1'b1, 0);
      add_idle(40, 1'b1);
      run_model();
   endtask

   initial begin
      logic [59:0] flip;
      int          ones[$];
      int          l;

      pat = SYNC_PAT;
      adc_data = IDLE_LVL; m_if.ready = 1'b1; stat_clr = 1'b0; rst_n = 1'b0;
      #2;
      check("rst.pam_data", 192'(m_if.pam_data), 192'(0));
      check("rst.valid", 192'(m_if.valid), 192'(0));
      check("rst.pilot_levels", pilot_levels, 192'(0));
      check("rst.pilot_valid", 192'(pilot_valid), 192'(0));
      check("rst.frame_sync", 192'(frame_sync), 192'(0));
      check("rst.frame_cnt", 192'(frame_cnt), 192'(0));
      check("rst.overflow", 192'(overflow), 192'(0));
      do_reset();

      // clean frame
      build_clean();
      run_stream(-1);
      results("clean", -1, 1'b0);
      check("clean.frames", 192'(frame_cnt), 192'(1));
      check("clean.pil0", 192'(seen_pil[11:0]), 192'(12'h800));
      check("clean.pil15", 192'(seen_pil[191:180]), 192'(12'h7FF));
      if (got.size() == 512) begin
         check("clean.first", 192'(got[0]), 192'(24'h000001));
         check("clean.last", 192'(got[511]), 192'(24'h3FE3FF));
      end

      // three flipped sync symbols still lock
      do_reset();
      flip = '0;
      while ($countones(flip) < 3) flip[$urandom_range(0, 59)] = 1'b1;
      new_stream(); add_idle(70, 1'b0); add_frame(flip, 1'b0, 1); add_idle(40, 1'b0);
      run_model();
      run_stream(-1);
      results("flip3", -1, 1'b0);
      check("flip3.frames", 192'(frame_cnt), 192'(1));

      // four flipped sync symbols must not lock
      do_reset();
      ones.delete();
      for (int b = 0; b < 60; b++) if (pat[b]) ones.push_back(b);
      flip = '0;
      while ($countones(flip) < 4) flip[ones[$urandom_range(0, ones.size() - 1)]] = 1'b1;
      new_stream(); add_idle(70, 1'b0); add_frame(flip, 1'b0, 1); add_idle(40, 1'b0);
      run_model();
      run_stream(-1);
      results("flip4", -1, 1'b0);
      check("flip4.frames", 192'(frame_cnt), 192'(0));

      // ready low for a whole frame: 16 words kept, rest dropped
      do_reset();
      build_clean();
      for (int k = 0; k < s_rdy.size(); k++) s_rdy[k] = 1'b0;
      run_stream(-1);
      results("noready", 16, 1'b1);
      if (got.size() == 16) check("noready.w15", 192'(got[15]), 192'(24'h01E01F));
      @(negedge clk); stat_clr = 1'b1;
      @(negedge clk); stat_clr = 1'b0;
      #1;
      check("statclr.overflow", 192'(overflow), 192'(0));
      check("statclr.frame_cnt", 192'(frame_cnt), 192'(0));

      // back-to-back frames, first payload carries the exact sync pattern
      do_reset();
      new_stream(); add_idle(50, 1'b0);
      add_frame(60'b0, 1'b0, 2); add_frame(60'b0, 1'b0, 1);
      add_idle(40, 1'b0);
      run_model();
      run_stream(-1);
      results("b2b", -1, 1'b0);
      check("b2b.frames", 192'(frame_cnt), 192'(2));
      check("b2b.nwords", 192'(got.size()), 192'(1024));

      // reset at payload sample 300, then the same frame again
      do_reset();
      build_clean();
      l = (m_lock.size() > 0) ? m_lock[0] : 0;
      run_stream(l + 17 + 301);
      rst_n = 1'b0;
      #1;
      check("midrst.valid", 192'(m_if.valid), 192'(0));
      check("midrst.pam_data", 192'(m_if.pam_data), 192'(0));
      check("midrst.pilot_levels", pilot_levels, 192'(0));
      check("midrst.pilot_valid", 192'(pilot_valid), 192'(0));
      check("midrst.frame_sync", 192'(frame_sync), 192'(0));
      check("midrst.frame_cnt", 192'(frame_cnt), 192'(0));
      check("midrst.overflow", 192'(overflow), 192'(0));
      @(negedge clk); rst_n = 1'b1;
      run_stream(-1);
      results("after_rst", -1, 1'b0);

      // FIFO filled, then ready toggles in phase with pushes: pop and push coincide
      do_reset();
      build_clean();
      l = (m_lock.size() > 0) ? m_lock[0] : 0;
      for (int j = 0; j < 1024 + 40; j++)
         s_rdy[l + 17 + j] = (j < 32) ? 1'b0 : (j[0] == 1'b1);
      run_stream(-1);
      results("toggle", -1, 1'b0);

      // stat_clr on the lock cycle wins over the increment
      do_reset();
      new_stream(); add_idle(40, 1'b0); add_frame(60'b0, 1'b0, 1); add_idle(40, 1'b0);
      run_model();
      if (m_lock.size() > 0) s_clr[m_lock[0]] = 1'b1;
      run_model();
      run_stream(-1);
      results("clr_prio", -1, 1'b0);
      check("clr_prio.frame_cnt", 192'(frame_cnt), 192'(0));

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/strip_head_frame.md
Name: strip_head_frame

Overview:
- Receive-side counterpart of the PAM transmit framer. Takes the ADC sample stream, one sample per clk.
- Hunts for the 60-symbol synchronisation header, captures the 2^PAM_ORDER pilot symbols, then extracts the 2^ADDR_MEM_WIDTH payload samples.
- Repacks payload samples into 2-sample words on a valid/ready stream toward the PAM demapper.
- Sits between the ADC capture interface and the PAM demap/equaliser.

Parameters:
- AD_CVER_WIDTH, 12, ADC sample width; samples are two's complement.
- ADDR_MEM_WIDTH, 10, log2 of payload samples per frame (1024).
- PAM_ORDER, 4, log2 of pilot count (16).
- SYNC_MAX_ERR, 3, maximum Hamming distance accepted for a sync match.
- SYNC_THR, 1024, signed slicer threshold for sync symbols.
- FIFO_AW, 4, log2 of output FIFO depth in words.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, reset: asynchronous, active-low.
- adc_data, input, AD_CVER_WIDTH, ADC sample, valid every cycle, no stall.
- M_out_pam_data, output, 2*AD_CVER_WIDTH, payload word: {earlier sample, later sample}.
- M_out_valid, output, 1, FIFO not empty.
- M_out_ready, input, 1, downstream accept.
- pilot_levels, output, (1<<PAM_ORDER)*AD_CVER_WIDTH, pilot k held in bits [k*W +: W].
- pilot_valid, output, 1, one-cycle pulse when all pilots are captured.
- frame_sync, output, 1, one-cycle pulse on sync lock.
- frame_cnt, output, 16, frames locked, wraps at 0xFFFF.
- overflow, output, 1, sticky; set when a word is dropped on a full FIFO.
- stat_clr, input, 1, synchronous clear of frame_cnt and overflow.

Behaviour:
- Reset values: M_out_pam_data=0, M_out_valid=0, pilot_levels=0, pilot_valid=0, frame_sync=0, frame_cnt=0, overflow=0. FSM is in HUNT, FIFO empty, sync shift register all zeros.
- Slicer: bit = 1 if $signed(adc_data) > SYNC_THR, else 0. So 0x7FF→1, 0xFFF→0, idle 0x080→0.
- Sync pattern: package constant SYNC_PAT[59:0] = {15'b000_0101_0011_0111, 45'b0}, transmitted MSB first. The 60-bit slicer shift register shifts left; the newest bit enters at bit 0.
- Match: popcount(shreg ^ SYNC_PAT) <= SYNC_MAX_ERR. Evaluated only in HUNT.
- FSM states: HUNT → PILOT → DATA → HUNT.
  - HUNT: on a match, frame_sync pulses, frame_cnt increments, go to PILOT.
  - The sample presented in the cycle after the 60th sync sample is pilot 0. Internal pipelining must preserve this alignment.
  - PILOT: store 2^PAM_ORDER consecutive samples into pilot_levels (index = arrival order). After the last pilot, pilot_valid pulses one cycle after that store. Go to DATA.
  - DATA: count 2^ADDR_MEM_WIDTH samples.
    - Even-index samples are held; each odd-index sample completes the word {held, current}, which is pushed.
    - After sample 2^ADDR_MEM_WIDTH-1, go to HUNT with the shift register cleared. Sync is not searched in PILOT or DATA.
- Latency: the word is visible on M_out_pam_data/M_out_valid no later than 2 cycles after its second sample, if the FIFO was empty.
- Output FIFO: 2^FIFO_AW words, first-word fall-through.
  - Pop when M_out_valid && M_out_ready.
  - Push and pop in the same cycle when full is legal: no drop.
  - Push when full without a pop: the word is dropped, overflow is set, and the frame continues.
- pilot_levels holds its value until the next frame's pilots complete.
- stat_clr has priority over a same-cycle frame_cnt increment: the result is 0.
- Reset mid-frame: immediate return to HUNT, FIFO flushed, partial word discarded.

Decomposition:
- Package frame_pkg holds SYNC_PAT, SYNC_LEN=60, the IDLE_LVL=12'h080 constant, and FSM state encodings.
- The transmit framer is migrated to the same package.
- One sub-module: sync_fifo (parameterised width/depth, FWFT, full/empty/count).
- Popcount is a local function, not a module.

Test Plan:
- Clean frame: 100 idle samples of 0x080, then the sync sequence, then pilots 0x800,0x911,…,0x7FF, then payload samples 0..1023, with M_out_ready=1.
  → frame_sync pulses once and frame_cnt=1.
  → pilot_valid pulses with pilot_levels[11:0]=0x800 and [191:180]=0x7FF.
  → 512 words are produced, first 0x000001, last 0x3FE3FF; overflow=0.
- Sync with 3 flipped symbols → lock, identical output. With 4 flipped symbols → no frame_sync, no words, frame_cnt=0.
- M_out_ready=0 for a whole frame → exactly 16 words held (0x000001..0x01E01F) and overflow=1. Raising ready drains those 16 in order. stat_clr clears overflow.
- Back-to-back frames whose payload contains the exact sync pattern → no false lock during DATA; frame_cnt=2; 1024 words total.
- rst_n asserted at payload sample 300 → all outputs return to reset values and the FIFO empties. The next full frame is received exactly as in the clean-frame test.
- Ready toggling every cycle while the FIFO is full during pushes → no drops when the pop coincides with the push, and word order is preserved.
